regfile_bus_arbiter: RTL
========================

Name: regfile_bus_arbiter

Overview:
Two-master arbiter that shares the single register-file access port (wr_en/rd_en/addr/wdata/rdata) between a host requester (m0) and an on-chip sequencer (m1).
- Uses a req/ack handshake with round-robin fairness.
- Issues exactly one single-cycle strobe per transaction and returns registered read data.
- Sits between the requesters and the register file / counter pair.

Parameters:
ADDR_W, 10, register-file address width
DATA_W, 32, data width
RD_LATENCY, 1, cycles from rf_rd_en strobe to valid rf_rdata; legal range 1..4

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 request; held high until m0_ack
m0_we  input  1  master 0 direction: 1=write, 0=read; stable while m0_req
m0_addr  input  ADDR_W  master 0 address; stable while m0_req
m0_wdata  input  DATA_W  master 0 write data; stable while m0_req
m0_ack  output  1  one-cycle completion pulse to master 0
m0_rdata  output  DATA_W  read data for master 0; valid when m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_* for master 1
rf_wr_en  output  1  register-file write strobe
rf_rd_en  output  1  register-file read strobe
rf_addr  output  ADDR_W  register-file address
rf_wdata  output  DATA_W  register-file write data
rf_rdata  input  DATA_W  register-file read data
busy  output  1  high in every state except IDLE
grant_id  output  1  owner of the current or last transaction (0=m0, 1=m1)

Behaviour:
- Reset (async, rst=1) clears all state and outputs:
  - FSM goes to IDLE.
  - All outputs are 0: rf_*, m*_ack, m*_rdata, busy, grant_id.
  - Round-robin pointer last_grant=1, so m0 wins the first contention.
- States:
  - IDLE:
    - If neither request is set, stay.
    - If one request is set, grant it.
    - If both are set, grant the master that is not last_grant.
    - On the grant edge: latch we/addr/wdata into internal registers, update last_grant and grant_id, go to ISSUE.
  - ISSUE:
    - Drive exactly one cycle of rf_wr_en (write) or rf_rd_en (read), using the latched addr/wdata.
    - Write → ACK. Read → WAIT with wait counter = RD_LATENCY-1.
  - WAIT:
    - If counter==0, capture rf_rdata into the granted master's m*_rdata at the clock edge, then → ACK.
    - Otherwise decrement and stay.
  - ACK:
    - Assert m*_ack of the granted master for exactly one cycle, then → IDLE.
- Latency from req rising (sampled in IDLE) to ack:
  - write: ack in 3rd cycle (IDLE → ISSUE → ACK).
  - read: ack in 3+RD_LATENCY cycle.
- Requester rules:
  - A requester must deassert req in its ack cycle or later.
  - Req still high in IDLE after ack is treated as a new transaction.
- Output stability:
  - rf_addr/rf_wdata hold their latched values outside the strobe cycle; no glitching to requester inputs.
  - m*_rdata holds its value until the next read completes for that master.
  - Writes never modify m*_rdata.
- rf_wr_en and rf_rd_en are never high together.
- At most one strobe is issued per grant.
- Requests arriving in any non-IDLE state wait; they are not lost while held.
- Round-robin: with both masters requesting continuously, grants strictly alternate m0, m1, m0, …
- Reset mid-transaction:
  - The transaction is abandoned and no ack is issued.
  - Strobes drop immediately (asynchronous).
- RD_LATENCY outside 1..4 is unsupported; elaboration-time check required.
- Wait counter is 2 bits wide.

Test Plan:
- Reset then single write from m0, addr=0x004, wdata=0xDEADBEEF → rf_wr_en high exactly 1 cycle with those values; m0_ack pulse 2 cycles after the grant edge; m1_ack stays 0.
- m1 read addr=0x008, RD_LATENCY=1, rf_rdata model returns 0x12345678 one cycle after the strobe → m1_rdata=0x12345678 coincident with the m1_ack pulse; m0_rdata unchanged.
- m0 and m1 request in the same cycle directly after reset → m0 granted first, m1 second; with both held continuously for 6 transactions, grant_id sequence is 0,1,0,1,0,1.
- RD_LATENCY=3 read → WAIT lasts 3 cycles; data captured exactly 3 cycles after rf_rd_en; ack 6 cycles after req sampled.
- m1 raises req while m0 write is in ISSUE → m1 served immediately after m0's ACK/IDLE cycle; no dropped or duplicated strobes (strobe count == ack count).
- rst asserted during WAIT of a read → rf_rd_en/ack/busy go 0 asynchronously; no ack after release; next request is serviced normally with m0 priority.

Source files
------------

// File: rtl/regfile_bus_arbiter.sv
// Two-master round-robin arbiter that shares the single register-file access port.
// Each grant issues one strobe; read data is captured into a per-master output register.
module regfile_bus_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy,
    output logic              grant_id
);
    // state | meaning
    // IDLE  | no transaction; arbitrate pending requests
    // ISSUE | single-cycle rf strobe using latched addr/wdata
    // WAIT  | count out the read latency, capture rf_rdata on the last cycle
    // ACK   | one-cycle ack pulse to the granted master

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_rd_latency
            $error("regfile_bus_arbiter: RD_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [1:0]        wait_cnt;
    logic              grant_any;
    logic              grant_sel;

    // Contention goes to the master that did not win last time.
    always_comb begin
        grant_any = m0_req | m1_req;
        grant_sel = m1_req & (~m0_req | ~last_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_any) state_next = ISSUE;
            ISSUE:   state_next = lat_we ? ACK : WAIT;
            WAIT:    if (wait_cnt == 2'd0) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                lat_we     <= grant_sel ? m1_we    : m0_we;
                lat_addr   <= grant_sel ? m1_addr  : m0_addr;
                lat_wdata  <= grant_sel ? m1_wdata : m0_wdata;
            end
            if (state == ISSUE) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (state == WAIT && wait_cnt == 2'd0) begin
                if (owner) begin
                    rdata1 <= rf_rdata;
                end else begin
                    rdata0 <= rf_rdata;
                end
            end
        end
    end

    // Address/data come straight from the latches so they never follow requester inputs.
    always_comb begin
        rf_wr_en = 1'b0;
        rf_rd_en = 1'b0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        unique case (state)
            ISSUE: begin
                rf_wr_en = lat_we;
                rf_rd_en = ~lat_we;
            end
            ACK: begin
                m0_ack = ~owner;
                m1_ack = owner;
            end
            default: ;
        endcase
        rf_addr  = lat_addr;
        rf_wdata = lat_wdata;
        m0_rdata = rdata0;
        m1_rdata = rdata1;
        busy     = (state != IDLE);
        grant_id = owner;
    end
endmodule
